// File: rtl/led_scene_sequencer.sv
// Steps through up to four LED scenes: fade down, swap timer/inverted, fade up, hold.
// Define LED_SCENE_AUTO_EN to compile in the hold counter and I_AUTO auto-advance.
module led_scene_sequencer #(
   parameter logic [2:0]  P_SCENE_NUM  = 3'd4,
   parameter logic [15:0] P_HOLD_TICKS = 16'd50000
) (
   input  logic       I_CLK_100MHZ,
   input  logic       I_RST_N,
   input  logic       I_CE_10KHZ,
   input  logic       I_NEXT,
   input  logic       I_AUTO,
   output logic [9:0] O_TIMER,
   output logic [6:0] O_BRIGHTNESS,
   output logic       O_INVERTED,
   output logic [1:0] O_SCENE,
   output logic       O_BUSY
);

   typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT, SWITCH} t_state;

   t_state     r_state;
   logic [1:0] r_scene;
   logic [9:0] r_timer;
   logic [6:0] r_bright;
   logic       r_inv;
   logic       r_busy;
   logic       r_pending;

   logic [6:0] w_target;
   logic [1:0] w_scene_nxt;
   logic       w_auto_adv;
   logic       w_advance;

   function automatic logic [9:0] f_timer(input logic [1:0] idx);
      case (idx)
         2'd0:    return 10'h0FF;
         2'd1:    return 10'h07F;
         2'd2:    return 10'h3FF;
         default: return 10'h01F;
      endcase
   endfunction

   function automatic logic [6:0] f_bright(input logic [1:0] idx);
      case (idx)
         2'd0:    return 7'd50;
         2'd1:    return 7'd100;
         2'd2:    return 7'd20;
         default: return 7'd75;
      endcase
   endfunction

   function automatic logic f_inv(input logic [1:0] idx);
      return idx[1];
   endfunction

   assign w_target = f_bright(r_scene);
   // ">=" also folds any out-of-range scene back to 0
   assign w_scene_nxt = ({1'b0, r_scene} >= (P_SCENE_NUM - 3'd1)) ? 2'd0 : r_scene + 2'd1;
   assign w_advance   = I_NEXT | r_pending | w_auto_adv;

`ifdef LED_SCENE_AUTO_EN
   logic [15:0] r_hold_cnt;

   assign w_auto_adv = I_AUTO & I_CE_10KHZ & (r_hold_cnt == (P_HOLD_TICKS - 16'd1));

   always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_hold_cnt <= '0;
      end else if ((r_state != HOLD) || !I_AUTO || w_advance) begin
         r_hold_cnt <= '0;
      end else if (I_CE_10KHZ) begin
         r_hold_cnt <= r_hold_cnt + 16'd1;
      end
   end
`else
   logic w_unused_auto;
   assign w_unused_auto = I_AUTO | (P_HOLD_TICKS == 16'd0);
   assign w_auto_adv    = 1'b0;
`endif

   always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_state   <= FADE_IN;
         r_scene   <= 2'd0;
         r_timer   <= 10'h0FF;
         r_bright  <= 7'd0;
         r_inv     <= 1'b0;
         r_busy    <= 1'b1;
         r_pending <= 1'b0;
      end else begin
         case (r_state)
            FADE_IN: begin
               if (I_NEXT) r_pending <= 1'b1;
               if (r_bright == w_target) begin
                  r_state <= HOLD;
                  r_busy  <= 1'b0;
               end else if (I_CE_10KHZ && (r_bright < w_target) && (r_bright < 7'd100)) begin
                  r_bright <= r_bright + 7'd1;
               end
            end
            HOLD: begin
               if (w_advance) begin
                  r_state   <= FADE_OUT;
                  r_busy    <= 1'b1;
                  r_pending <= 1'b0;
               end
            end
            FADE_OUT: begin
               if (I_NEXT) r_pending <= 1'b1;
               if (r_bright == 7'd0) begin
                  r_state <= SWITCH;
               end else if (I_CE_10KHZ) begin
                  r_bright <= r_bright - 7'd1;
               end
            end
            SWITCH: begin
               if (I_NEXT) r_pending <= 1'b1;
               r_scene <= w_scene_nxt;
               r_timer <= f_timer(w_scene_nxt);
               r_inv   <= f_inv(w_scene_nxt);
               r_state <= FADE_IN;
            end
         endcase
      end
   end

   assign O_TIMER      = r_timer;
   assign O_BRIGHTNESS = r_bright;
   assign O_INVERTED   = r_inv;
   assign O_SCENE      = r_scene;
   assign O_BUSY       = r_busy;

endmodule

// File: doc/led_scene_sequencer.md
# led_scene_sequencer

Scene sequencer for the user-LED rainbow path. It produces the timer, brightness and inverted-mode settings that the rainbow controller consumes, so those values no longer come from the VIO. It steps through a fixed table of up to four lighting scenes. On every scene change it fades brightness down to 0, swaps the timer and inverted settings, then fades up to the new scene's brightness. A request pulse advances the scene, and an optional auto mode advances it after a hold interval.

## Interface
Parameters:
- P_SCENE_NUM, 3'd4: number of active scenes, legal range 1..4; the scene index wraps from P_SCENE_NUM-1 to 0.
- P_HOLD_TICKS, 16'd50000: auto-mode hold time in I_CE_10KHZ ticks (default 5 s).

Ports:
- I_CLK_100MHZ  in  1  100 MHz clock; the only clock.
- I_RST_N  in  1  asynchronous, active-low reset.
- I_CE_10KHZ  in  1  10 kHz clock enable, one clock cycle wide.
- I_NEXT  in  1  advance request; a single-cycle pulse, synchronous to the clock.
- I_AUTO  in  1  level; 1 enables auto-advance.
- O_TIMER  out  10  transition-speed setting for the rainbow controller.
- O_BRIGHTNESS  out  7  PWM brightness setting, 0..100.
- O_INVERTED  out  1  inverted-transition setting.
- O_SCENE  out  2  current scene index.
- O_BUSY  out  1  high while a fade or swap is in progress.

## Operation
- Scene table, as {timer, brightness, inverted}, hard-coded constants:
  - scene 0: {10'h0FF, 50, 0}
  - scene 1: {10'h07F, 100, 0}
  - scene 2: {10'h3FF, 20, 1}
  - scene 3: {10'h01F, 75, 1}
- FSM states: FADE_IN, HOLD, FADE_OUT, SWITCH.
- FADE_IN: on each CE, O_BRIGHTNESS increments by 1 until it equals the target. When equal, go to HOLD. The equality check runs every clock, so a target already reached exits on the next clock.
- HOLD: the hold counter increments on each CE. Advance to FADE_OUT when an advance event occurs:
  - an I_NEXT pulse,
  - a pending request, or
  - (auto) I_AUTO=1 and the hold counter reaches P_HOLD_TICKS-1 on a CE.
  - The hold counter clears on exit from HOLD and whenever I_AUTO=0.
- FADE_OUT: on each CE, O_BRIGHTNESS decrements by 1. When it reaches 0, go to SWITCH.
- SWITCH: lasts one clock.
  - O_SCENE advances to (O_SCENE+1) mod P_SCENE_NUM.
  - O_TIMER and O_INVERTED load from the new scene.
  - Then go to FADE_IN.
- Pending request:
  - An I_NEXT pulse in FADE_OUT, SWITCH or FADE_IN sets a 1-deep pending flag; further pulses while it is set are dropped.
  - The flag is consumed on the first HOLD cycle, which gives an immediate FADE_OUT.
- Brightness arithmetic is 7-bit unsigned and saturates at 0 and 100; it never wraps.
- O_TIMER and O_INVERTED change only in SWITCH, while brightness is 0.

## Timing
- All outputs are registered.
- Reset values:
  - O_SCENE=0, O_TIMER=10'h0FF, O_BRIGHTNESS=0, O_INVERTED=0
  - O_BUSY=1, state FADE_IN, pending=0, hold counter=0
  - So the block fades into scene 0 after reset.
- I_NEXT sampled in HOLD: state is FADE_OUT and O_BUSY=1 one clock later.
- Fade durations:
  - Fade-out takes B CE ticks, where B is the current brightness.
  - Fade-in takes the target brightness in CE ticks.
  - Scene 0 to scene 1: 50 + 1 clock + 100 ticks.
- O_BUSY=0 exactly in HOLD.
- Simultaneous I_NEXT and auto expiry in the same cycle produce one advance.
- Reset asserted mid-fade returns all outputs to their reset values asynchronously. Release is synchronous to the next clock edge.
- With P_SCENE_NUM=1, SWITCH reloads scene 0. The fade-out/fade-in still occurs.

## Configuration
- LED_SCENE_AUTO_EN defined: the hold counter and I_AUTO auto-advance are compiled in, as described above.
- LED_SCENE_AUTO_EN undefined:
  - The hold counter is removed and I_AUTO is ignored; the port remains.
  - Only I_NEXT and the pending flag cause an advance.
  - HOLD persists indefinitely.

## Test plan
- Reset release, I_AUTO=0: O_BRIGHTNESS ramps 0→50 over 50 CEs, then O_BUSY=0, O_SCENE=0, O_TIMER=0x0FF.
- I_NEXT in HOLD of scene 0: O_BUSY=1 next clock; brightness 50→0, then O_SCENE=1, O_TIMER=0x07F, brightness 0→100; O_INVERTED stays 0.
- Three I_NEXT pulses during one fade: exactly one pending advance follows. The scene goes 1→2, then immediately 2→3, and the third pulse is lost.
- With LED_SCENE_AUTO_EN, P_HOLD_TICKS=4, I_AUTO=1: the scene advances after 4 CEs in HOLD and wraps 3→0 with O_TIMER=0x0FF. With the macro undefined, no advance occurs.
- I_RST_N pulsed low mid-FADE_OUT at brightness 30: outputs are immediately O_BRIGHTNESS=0, O_SCENE=0, O_BUSY=1, followed by a fresh fade-in to 50.
